// File: rtl/phase_frame_sequencer.sv
// phase_frame_sequencer
// Command front end for the transducer array phase registers. It accepts
// 32-bit command words over a valid/ready handshake and decodes them into
// broadcast phase writes, calibration captures and frame commits. Malformed
// commands raise sticky error flags.
// Optional feature: define PHASE_SEQ_WATCHDOG_EN to build the frame-incomplete
// watchdog. Without it, err_timeout is tied to 0 and COLLECT never times out.
module phase_frame_sequencer #(
    parameter int NUM_CHANNELS = 256,
    parameter int CALIB_HOLD   = 4,
    parameter int WDOG_CYCLES  = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        err_clear,
    output logic [31:0] phase_data,
    output logic        phase_parse_en,
    output logic        phase_calib_en,
    output logic        frame_commit,
    output logic [15:0] frame_count,
    output logic        busy,
    output logic        err_channel,
    output logic        err_opcode,
    output logic        err_timeout
);

    localparam logic [7:0] LP_OP_WRITE  = 8'h00;
    localparam logic [7:0] LP_OP_CALIB  = 8'h01;
    localparam logic [7:0] LP_OP_COMMIT = 8'h02;
    localparam logic [8:0] LP_NUM_CH    = 9'(NUM_CHANNELS);
    localparam int         LP_HOLD_W    = $clog2(CALIB_HOLD + 1);
    localparam logic [LP_HOLD_W-1:0] LP_HOLD_LOAD = LP_HOLD_W'(CALIB_HOLD - 1);

    // Reject configurations the datapath cannot represent.
    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 256) begin : g_bad_num_channels
        $error("NUM_CHANNELS must be in 1..256");
    end
    if (CALIB_HOLD < 1) begin : g_bad_calib_hold
        $error("CALIB_HOLD must be at least 1");
    end
    if (WDOG_CYCLES < 1) begin : g_bad_wdog_cycles
        $error("WDOG_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CALIB   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LP_HOLD_W-1:0]   r_hold;
    logic [LP_HOLD_W-1:0]   w_hold_nxt;
    logic [15:0]            r_wr_cnt;
    logic [15:0]            w_wr_cnt_nxt;
    logic [15:0]            r_frame_count;
    logic [15:0]            w_frame_nxt;
    logic [31:0]            r_phase_data;
    logic [31:0]            w_phase_nxt;
    logic                   r_cmd_ready;
    logic                   r_busy;
    logic                   r_parse_en;
    logic                   r_calib_en;
    logic                   r_commit;
    logic                   r_err_channel;
    logic                   r_err_opcode;
    logic                   w_parse_nxt;
    logic                   w_calib_nxt;
    logic                   w_commit_nxt;
    logic                   w_set_ch;
    logic                   w_set_op;
    logic                   w_set_to;
    logic                   w_accept;
    logic                   w_chan_ok;
    logic [7:0]             w_opcode;
    logic                   w_wdog_expire;

    assign w_accept  = cmd_valid & r_cmd_ready;
    assign w_opcode  = cmd_data[31:24];
    assign w_chan_ok = ({1'b0, cmd_data[15:8]} < LP_NUM_CH);

`ifdef PHASE_SEQ_WATCHDOG_EN
    localparam int LP_WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [LP_WDOG_W-1:0] LP_WDOG_LAST = LP_WDOG_W'(WDOG_CYCLES - 1);

    logic [LP_WDOG_W-1:0] r_wdog;
    logic [LP_WDOG_W-1:0] w_wdog_nxt;
    logic                 r_err_timeout;

    // Expiry is the last idle cycle of the window; an accept in it wins.
    assign w_wdog_expire = (r_state == ST_COLLECT) && !w_accept && (r_wdog == LP_WDOG_LAST);

    // Watchdog counts idle cycles in COLLECT and restarts on any accept.
    always_comb begin
        w_wdog_nxt = '0;
        if (r_state == ST_COLLECT && !w_accept && !w_wdog_expire) begin
            w_wdog_nxt = r_wdog + LP_WDOG_W'(1);
        end else begin
            w_wdog_nxt = '0;
        end
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog        <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_wdog        <= w_wdog_nxt;
            r_err_timeout <= w_set_to | (r_err_timeout & ~err_clear);
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_wdog_expire = 1'b0;
    assign err_timeout   = 1'b0;
`endif

    // Command decode: next state, strobes, counters and error requests.
    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold;
        w_wr_cnt_nxt = r_wr_cnt;
        w_frame_nxt  = r_frame_count;
        w_phase_nxt  = r_phase_data;
        w_parse_nxt  = 1'b0;
        w_calib_nxt  = 1'b0;
        w_commit_nxt = 1'b0;
        w_set_ch     = 1'b0;
        w_set_op     = 1'b0;
        w_set_to     = 1'b0;
        case (r_state)
            ST_IDLE, ST_COLLECT: begin
                if (w_accept) begin
                    case (w_opcode)
                        LP_OP_WRITE: begin
                            // The bus follows every write word, even rejected ones.
                            w_phase_nxt = cmd_data;
                            if (w_chan_ok) begin
                                w_parse_nxt = 1'b1;
                                w_state_nxt = ST_COLLECT;
                                if (r_wr_cnt != 16'hFFFF) begin
                                    w_wr_cnt_nxt = r_wr_cnt + 16'd1;
                                end else begin
                                    w_wr_cnt_nxt = r_wr_cnt;
                                end
                            end else begin
                                w_set_ch = 1'b1;
                            end
                        end
                        LP_OP_CALIB: begin
                            if (r_state == ST_IDLE) begin
                                w_calib_nxt = 1'b1;
                                w_state_nxt = ST_CALIB;
                                w_hold_nxt  = LP_HOLD_LOAD;
                            end else begin
                                w_set_op = 1'b1;
                            end
                        end
                        LP_OP_COMMIT: begin
                            // A commit with no pending writes is silently ignored.
                            if (r_state == ST_COLLECT) begin
                                w_commit_nxt = 1'b1;
                                w_frame_nxt  = r_frame_count + 16'd1;
                                w_wr_cnt_nxt = 16'd0;
                                w_state_nxt  = ST_IDLE;
                            end else begin
                                w_commit_nxt = 1'b0;
                            end
                        end
                        default: begin
                            w_set_op = 1'b1;
                        end
                    endcase
                end else if (w_wdog_expire) begin
                    w_state_nxt  = ST_IDLE;
                    w_wr_cnt_nxt = 16'd0;
                    w_set_to     = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_CALIB: begin
                if (r_hold == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_nxt = r_hold - LP_HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, counters and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold        <= '0;
            r_wr_cnt      <= 16'd0;
            r_frame_count <= 16'd0;
            r_phase_data  <= 32'd0;
            r_cmd_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_parse_en    <= 1'b0;
            r_calib_en    <= 1'b0;
            r_commit      <= 1'b0;
            r_err_channel <= 1'b0;
            r_err_opcode  <= 1'b0;
        end else begin
            r_hold        <= w_hold_nxt;
            r_wr_cnt      <= w_wr_cnt_nxt;
            r_frame_count <= w_frame_nxt;
            r_phase_data  <= w_phase_nxt;
            r_cmd_ready   <= (w_state_nxt != ST_CALIB);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_parse_en    <= w_parse_nxt;
            r_calib_en    <= w_calib_nxt;
            r_commit      <= w_commit_nxt;
            r_err_channel <= w_set_ch | (r_err_channel & ~err_clear);
            r_err_opcode  <= w_set_op | (r_err_opcode & ~err_clear);
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign busy           = r_busy;
    assign phase_data     = r_phase_data;
    assign phase_parse_en = r_parse_en;
    assign phase_calib_en = r_calib_en;
    assign frame_commit   = r_commit;
    assign frame_count    = r_frame_count;
    assign err_channel    = r_err_channel;
    assign err_opcode     = r_err_opcode;

endmodule

// File: doc/phase_frame_sequencer.md
Name: phase_frame_sequencer

Overview:
Command front end for the transducer array's per-channel phase registers. It accepts 32-bit command words from the host link FIFO over a valid/ready handshake and decodes them. It then drives the shared phase_data bus and the phase_parse_en / phase_calib_en strobes that are broadcast to every channel's phase register. It also tracks frame boundaries, issues a frame_commit strobe for the downstream PWM double-buffer, and flags malformed commands.

Parameters:
NUM_CHANNELS, 256, number of addressable channels; valid channel IDs are 0..NUM_CHANNELS-1 (max 256).
CALIB_HOLD, 4, cycles cmd_ready stays low after a calibrate strobe (min 1).
WDOG_CYCLES, 1000000, frame-incomplete timeout in cycles (used only with the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_data  in  32  command word: [31:24] opcode, [16] pwm enable, [15:8] channel, [7:0] phase
cmd_valid  in  1  command word present
cmd_ready  out  1  sequencer can accept a word this cycle
err_clear  in  1  clears sticky error flags
phase_data  out  32  broadcast word to the channel phase registers
phase_parse_en  out  1  one-cycle phase write strobe
phase_calib_en  out  1  one-cycle calibration capture strobe
frame_commit  out  1  one-cycle frame-complete strobe
frame_count  out  16  committed-frame counter
busy  out  1  high in COLLECT or CALIB_HOLD
err_channel  out  1  sticky: channel >= NUM_CHANNELS
err_opcode  out  1  sticky: unknown or illegal-in-state opcode
err_timeout  out  1  sticky: watchdog expired (tied 0 without the macro)

Behaviour:
- Reset values: all outputs 0, except cmd_ready = 1 from the first cycle after reset deasserts. State goes to IDLE; write counter and watchdog counter clear. Reset mid-frame discards the frame with no commit.
- Accept occurs when cmd_valid && cmd_ready. All outputs are registered. Strobes assert exactly 1 cycle after the accept cycle and last exactly 1 cycle.
- phase_data loads cmd_data on every accepted opcode 0x00 word, including out-of-range channels. It holds its value otherwise.
- Opcode 0x00 PHASE_WRITE, legal in IDLE and COLLECT:
  - Channel < NUM_CHANNELS: pulse phase_parse_en, increment write counter (saturates at 0xFFFF), go to COLLECT.
  - Channel >= NUM_CHANNELS: no strobe, set err_channel, no state change.
- Opcode 0x01 CALIBRATE, legal only in IDLE:
  - Pulse phase_calib_en and go to CALIB_HOLD.
  - cmd_ready is 0 for CALIB_HOLD cycles starting the cycle after the accept, then the block returns to IDLE.
  - In COLLECT the word is dropped and err_opcode is set.
- Opcode 0x02 COMMIT:
  - In COLLECT: pulse frame_commit, frame_count += 1 (wraps 0xFFFF -> 0), clear write counter, go to IDLE.
  - In IDLE (zero writes): ignored silently; no strobe, count unchanged.
- Any other opcode: dropped, err_opcode set, no state change.
- States: IDLE, COLLECT, CALIB_HOLD. cmd_ready = 1 in IDLE and COLLECT, 0 in CALIB_HOLD. Back-to-back accepts are allowed every cycle in IDLE/COLLECT.
- Sticky errors: err_clear clears them on the next cycle. If err_clear and a new error occur in the same cycle, the error wins (flag stays 1).
- Only one strobe output is high in any cycle.

Optional Feature:
PHASE_SEQ_WATCHDOG_EN
- With the macro:
  - In COLLECT, a counter increments every cycle without an accepted word and resets on each accept.
  - On reaching WDOG_CYCLES: state goes to IDLE, the write counter clears, err_timeout is set. No frame_commit is issued and frame_count is unchanged.
  - An accept in the expiry cycle takes priority; the timer resets and no timeout occurs.
- Without the macro: no counter is built, err_timeout is constant 0, and COLLECT persists indefinitely.

Test Plan:
- Reset, then accept 0x0001_0380 -> next cycle phase_parse_en=1, phase_data=0x0001_0380, busy=1; following cycle phase_parse_en=0.
- Writes to ch 0,1,2 then 0x0200_0000 -> one frame_commit pulse, frame_count 0->1, busy=0; a second COMMIT in IDLE -> no pulse, count stays 1.
- CALIBRATE (0x0100_0000) in IDLE, CALIB_HOLD=4 -> phase_calib_en 1 cycle; cmd_ready low exactly 4 cycles; a word held valid is accepted on the 5th cycle after the accept.
- NUM_CHANNELS=64, write to ch 0x40 -> no phase_parse_en, err_channel=1. CALIBRATE in COLLECT -> err_opcode=1, no phase_calib_en. Opcode 0x7F -> err_opcode. err_clear coincident with a new bad opcode -> flag stays 1; err_clear alone -> 0.
- Preset frame_count to 0xFFFF via 65535 frames (or force) then COMMIT -> 0x0000. Assert rst mid-COLLECT -> no commit, all outputs 0, cmd_ready=1 the cycle after release.
- With PHASE_SEQ_WATCHDOG_EN and WDOG_CYCLES=16: one write then idle 16 cycles -> err_timeout=1, busy=0, frame_count unchanged. A write on cycle 16 instead -> no timeout.
